// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, SYSTEM
// funct3 encodings, trap constants and the redirect FSM state type.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csrsel_e;

  localparam int ILLEGAL_INSTR = 2;
  localparam int MIE_BIT       = 3;
  localparam int MPIE_BIT      = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } redir_state_e;

  function automatic logic is_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, CSR_MHARTID:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// Two-word performance counter with per-half software write ports. Any
// write in a cycle suppresses that cycle's increment for the whole counter.
module csr_counter64 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc_en,
  input  logic         i_wr_lo,
  input  logic         i_wr_hi,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi
);

  logic [2*W-1:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) r_count[W-1:0]   <= i_wdata;
      if (i_wr_hi) r_count[2*W-1:W] <= i_wdata;
    end else if (i_inc_en) begin
      r_count <= r_count + (2*W)'(1);
    end
  end

  assign o_lo = r_count[W-1:0];
  assign o_hi = r_count[2*W-1:W];

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR responder: services CSRRW/S/C(I), owns the trap CSRs and
// counters, and converts traps and MRET into a registered fetch redirect.
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter int              HART_ID     = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      csrsel,
  input  logic            csrread,
  input  logic            csrwrite,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      uimm,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            illegal_ins,
  input  logic            is_mret,
  input  logic [XLEN-1:0] ins_pc,
  input  logic [31:0]     ins_word,
  input  logic            retire,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mie_out
);

  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic            r_mie, r_mpie;
  logic [XLEN-1:0] r_redirect_pc;
  redir_state_e    r_state, w_state_next;

  logic [XLEN-1:0] w_mstatus, w_old, w_src, w_new;
  logic            w_impl, w_trap, w_mret, w_wr;
  logic [XLEN-1:0] w_mcycle_lo, w_mcycle_hi, w_minstret_lo, w_minstret_hi;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through a case/if can leave it unassigned and infer a latch.
  always_comb begin
    w_mstatus           = '0;
    w_mstatus[MIE_BIT]  = r_mie;
    w_mstatus[MPIE_BIT] = r_mpie;
  end

  always_comb begin
    w_old = '0;
    case (csr_addr)
      CSR_MSTATUS:   w_old = w_mstatus;
      CSR_MTVEC:     w_old = r_mtvec;
      CSR_MSCRATCH:  w_old = r_mscratch;
      CSR_MEPC:      w_old = r_mepc;
      CSR_MCAUSE:    w_old = r_mcause;
      CSR_MTVAL:     w_old = r_mtval;
      CSR_MCYCLE:    w_old = w_mcycle_lo;
      CSR_MCYCLEH:   w_old = w_mcycle_hi;
      CSR_MINSTRET:  w_old = w_minstret_lo;
      CSR_MINSTRETH: w_old = w_minstret_hi;
      CSR_MHARTID:   w_old = XLEN'(HART_ID);
      default:       w_old = '0;
    endcase
  end

  assign w_impl      = is_implemented(csr_addr);
  assign csr_illegal = ((csrread | csrwrite) & ~w_impl)
                     | (csrwrite & (csr_addr == CSR_MHARTID));
  assign csr_rdata   = (csrread & w_impl) ? w_old : '0;

  assign w_src = csrsel[2] ? XLEN'(uimm) : rs1_data;

  always_comb begin
    w_new = w_old;
    case (csrsel_e'(csrsel))
      CSR_RW, CSR_RWI: w_new = w_src;
      CSR_RS, CSR_RSI: w_new = w_old | w_src;
      CSR_RC, CSR_RCI: w_new = w_old & ~w_src;
      default:         w_new = w_old;
    endcase
  end

  // Trap outranks MRET, and both outrank a software CSR write.
  assign w_trap = illegal_ins | csr_illegal;
  assign w_mret = is_mret & ~w_trap;
  assign w_wr   = csrwrite & ~w_trap & ~is_mret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b1;
      r_mtvec    <= MTVEC_RESET;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (w_trap) begin
      r_mepc   <= ins_pc & ~XLEN'(3);
      r_mcause <= XLEN'(ILLEGAL_INSTR);
      r_mtval  <= XLEN'(ins_word);
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (w_mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          r_mie  <= w_new[MIE_BIT];
          r_mpie <= w_new[MPIE_BIT];
        end
        CSR_MTVEC:    r_mtvec    <= w_new & ~XLEN'(3);
        CSR_MSCRATCH: r_mscratch <= w_new;
        CSR_MEPC:     r_mepc     <= w_new & ~XLEN'(3);
        CSR_MCAUSE:   r_mcause   <= w_new;
        CSR_MTVAL:    r_mtval    <= w_new;
        default: ;
      endcase
    end
  end

  csr_counter64 #(.W(XLEN)) u_mcycle (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc_en (1'b1),
    .i_wr_lo  (w_wr & (csr_addr == CSR_MCYCLE)),
    .i_wr_hi  (w_wr & (csr_addr == CSR_MCYCLEH)),
    .i_wdata  (w_new),
    .o_lo     (w_mcycle_lo),
    .o_hi     (w_mcycle_hi)
  );

  csr_counter64 #(.W(XLEN)) u_minstret (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc_en (retire),
    .i_wr_lo  (w_wr & (csr_addr == CSR_MINSTRET)),
    .i_wr_hi  (w_wr & (csr_addr == CSR_MINSTRETH)),
    .i_wdata  (w_new),
    .o_lo     (w_minstret_lo),
    .o_hi     (w_minstret_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // A fresh event while already redirecting simply re-arms REDIR.
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  if (w_trap | is_mret) w_state_next = ST_REDIR;
      ST_REDIR: if (w_trap | is_mret) w_state_next = ST_REDIR;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_redirect_pc <= '0;
    else if (w_trap)  r_redirect_pc <= r_mtvec;
    else if (is_mret) r_redirect_pc <= r_mepc;
  end

  assign redirect    = (r_state == ST_REDIR);
  assign redirect_pc = r_redirect_pc;
  assign mie_out     = r_mie;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus random traffic,
// all compared against a behavioural CSR model held in the bench.
module tb_csr_file;
  import csr_pkg::*;

  localparam logic [31:0] TB_MTVEC = 32'h0000_0200;
  localparam int          TB_HART  = 3;

  logic        clk, rst_n;
  logic [11:0] csr_addr;
  logic [2:0]  csrsel;
  logic        csrread, csrwrite;
  logic [31:0] rs1_data;
  logic [4:0]  uimm;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        illegal_ins, is_mret;
  logic [31:0] ins_pc, ins_word;
  logic        retire;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mie_out;

  csr_file #(.XLEN(32), .MTVEC_RESET(TB_MTVEC), .HART_ID(TB_HART)) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csrsel(csrsel),
    .csrread(csrread), .csrwrite(csrwrite), .rs1_data(rs1_data), .uimm(uimm),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .illegal_ins(illegal_ins),
    .is_mret(is_mret), .ins_pc(ins_pc), .ins_word(ins_word), .retire(retire),
    .redirect(redirect), .redirect_pc(redirect_pc), .mie_out(mie_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  sel;
    logic        rd, wr;
    logic [31:0] rs1;
    logic [4:0]  uimm;
    logic        ill, mret;
    logic [31:0] pc, word;
    logic        ret;
  } op_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic        m_mie, m_mpie, m_redir;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
  logic [63:0] m_cycle, m_instret;

  logic [31:0] rd_v;
  logic        il_v;

  logic [11:0] addr_list [13] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                  12'hF14, 12'h7C0, 12'h301};
  logic [2:0]  sel_list [6]   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b1; m_mtvec = TB_MTVEC; m_mscratch = '0;
    m_mepc = '0; m_mcause = '0; m_mtval = '0; m_cycle = '0; m_instret = '0;
    m_redir = 1'b0; m_rpc = '0;
  endtask

  function automatic logic m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                     12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return ({31'b0, m_mpie} << 7) | ({31'b0, m_mie} << 3);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'hF14: return 32'(TB_HART);
      default: return 32'h0;
    endcase
  endfunction

  function automatic op_t op_idle();
    op_t o;
    o.addr = '0; o.sel = '0; o.rd = 0; o.wr = 0; o.rs1 = '0; o.uimm = '0;
    o.ill = 0; o.mret = 0; o.pc = '0; o.word = '0; o.ret = 0;
    return o;
  endfunction

  function automatic op_t op_csr(input logic [11:0] a, input logic [2:0] s,
                                 input logic r, input logic w, input logic [31:0] v);
    op_t o = op_idle();
    o.addr = a; o.sel = s; o.rd = r; o.wr = w;
    if (s[2]) o.uimm = v[4:0];
    else      o.rs1  = v;
    return o;
  endfunction

  function automatic op_t op_trap(input logic [31:0] pc, input logic [31:0] word);
    op_t o = op_idle();
    o.ill = 1; o.pc = pc; o.word = word;
    return o;
  endfunction

  // One cycle: compare registered outputs, drive the op, compare combinational
  // outputs, then advance the model across the coming clock edge.
  task automatic step(input op_t op, input string name,
                      output logic [31:0] rdata_obs, output logic ill_obs);
    logic [31:0] old, src, nv, exp_rd;
    logic        ill, trap, mret, wr;
    logic [63:0] cyc_n, ins_n;

    n_tests++;
    if (redirect !== m_redir) begin
      n_fail++; $display("FAIL %s redirect got %b exp %b", name, redirect, m_redir);
    end
    n_tests++;
    if (redirect_pc !== m_rpc) begin
      n_fail++; $display("FAIL %s redirect_pc got %h exp %h", name, redirect_pc, m_rpc);
    end
    n_tests++;
    if (mie_out !== m_mie) begin
      n_fail++; $display("FAIL %s mie_out got %b exp %b", name, mie_out, m_mie);
    end

    csr_addr = op.addr; csrsel = op.sel; csrread = op.rd; csrwrite = op.wr;
    rs1_data = op.rs1; uimm = op.uimm; illegal_ins = op.ill; is_mret = op.mret;
    ins_pc = op.pc; ins_word = op.word; retire = op.ret;
    #1;

    old    = m_read(op.addr);
    ill    = ((op.rd || op.wr) && !m_impl(op.addr)) || (op.wr && op.addr == 12'hF14);
    exp_rd = (op.rd && m_impl(op.addr)) ? old : 32'h0;
    rdata_obs = csr_rdata;
    ill_obs   = csr_illegal;
    n_tests++;
    if (csr_rdata !== exp_rd) begin
      n_fail++; $display("FAIL %s csr_rdata got %h exp %h", name, csr_rdata, exp_rd);
    end
    n_tests++;
    if (csr_illegal !== ill) begin
      n_fail++; $display("FAIL %s csr_illegal got %b exp %b", name, csr_illegal, ill);
    end

    trap  = op.ill || ill;
    mret  = op.mret && !trap;
    wr    = op.wr && !trap && !op.mret;
    src   = op.sel[2] ? {27'b0, op.uimm} : op.rs1;
    case (op.sel)
      3'b001, 3'b101: nv = src;
      3'b010, 3'b110: nv = old | src;
      3'b011, 3'b111: nv = old & ~src;
      default:        nv = old;
    endcase
    cyc_n = m_cycle + 64'd1;
    ins_n = m_instret + (op.ret ? 64'd1 : 64'd0);

    m_redir = trap || mret;
    if (trap) begin
      m_rpc = m_mtvec; m_mepc = op.pc & ~32'd3; m_mcause = 32'd2;
      m_mtval = op.word; m_mpie = m_mie; m_mie = 1'b0;
    end else if (mret) begin
      m_rpc = m_mepc; m_mie = m_mpie; m_mpie = 1'b1;
    end else if (wr) begin
      case (op.addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec = nv & ~32'd3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'd3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: cyc_n = {m_cycle[63:32], nv};
        12'hB80: cyc_n = {nv, m_cycle[31:0]};
        12'hB02: ins_n = {m_instret[63:32], nv};
        12'hB82: ins_n = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle = cyc_n;
    m_instret = ins_n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 11; i++)
      step(op_csr(addr_list[i], 3'b010, 1, 0, 0), "reset_read", rd_v, il_v);
  endtask

  task automatic test_scratch();
    step(op_csr(CSR_MSCRATCH, 3'b001, 1, 1, 32'hDEADBEEF), "scratch_rw", rd_v, il_v);
    step(op_csr(CSR_MSCRATCH, 3'b010, 1, 0, 0), "scratch_rs", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL scratch_rs got %h exp %h", rd_v, 32'hDEADBEEF);
    end
    step(op_csr(CSR_MSCRATCH, 3'b010, 1, 0, 0), "scratch_hold", rd_v, il_v);
  endtask

  task automatic test_mstatus();
    step(op_csr(CSR_MSTATUS, 3'b110, 1, 1, 8), "mstatus_rsi", rd_v, il_v);
    n_tests++;
    if (mie_out !== 1'b1) begin
      n_fail++; $display("FAIL mstatus_set mie_out got %b exp 1", mie_out);
    end
    step(op_csr(CSR_MSTATUS, 3'b111, 1, 1, 8), "mstatus_rci", rd_v, il_v);
    step(op_csr(CSR_MSTATUS, 3'b010, 1, 0, 0), "mstatus_read", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'h80 || mie_out !== 1'b0) begin
      n_fail++; $display("FAIL mstatus_clear got %h/%b exp 00000080/0", rd_v, mie_out);
    end
  endtask

  task automatic test_trap();
    step(op_csr(CSR_MTVEC, 3'b001, 0, 1, 32'h100), "trap_mtvec", rd_v, il_v);
    step(op_csr(CSR_MSTATUS, 3'b110, 0, 1, 8), "trap_mie", rd_v, il_v);
    step(op_trap(32'h44, 32'hFFFF_FFFF), "trap_fire", rd_v, il_v);
    n_tests++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h100 || mie_out !== 1'b0) begin
      n_fail++; $display("FAIL trap_redirect got %b/%h/%b exp 1/00000100/0",
                         redirect, redirect_pc, mie_out);
    end
    step(op_csr(CSR_MEPC, 3'b010, 1, 0, 0), "trap_mepc", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'h44) begin n_fail++; $display("FAIL trap_mepc got %h exp 00000044", rd_v); end
    step(op_csr(CSR_MCAUSE, 3'b010, 1, 0, 0), "trap_mcause", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'd2) begin n_fail++; $display("FAIL trap_mcause got %h exp 00000002", rd_v); end
    step(op_csr(CSR_MTVAL, 3'b010, 1, 0, 0), "trap_mtval", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL trap_mtval got %h exp ffffffff", rd_v); end
    step(op_csr(CSR_MSTATUS, 3'b010, 1, 0, 0), "trap_mstatus", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'h80) begin n_fail++; $display("FAIL trap_mstatus got %h exp 00000080", rd_v); end
  endtask

  task automatic test_mret();
    op_t o;
    step(op_csr(CSR_MEPC, 3'b001, 0, 1, 32'h48), "mret_mepc", rd_v, il_v);
    o = op_idle(); o.mret = 1;
    step(o, "mret_fire", rd_v, il_v);
    n_tests++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h48 || mie_out !== 1'b1) begin
      n_fail++; $display("FAIL mret_redirect got %b/%h/%b exp 1/00000048/1",
                         redirect, redirect_pc, mie_out);
    end
    step(op_idle(), "mret_pulse", rd_v, il_v);
    n_tests++;
    if (redirect !== 1'b0) begin n_fail++; $display("FAIL mret_deassert got %b exp 0", redirect); end
  endtask

  task automatic test_counter();
    logic [31:0] hi0;
    step(op_csr(CSR_MCYCLEH, 3'b010, 1, 0, 0), "cnt_hi0", hi0, il_v);
    step(op_csr(CSR_MCYCLE, 3'b001, 0, 1, 32'hFFFF_FFFF), "cnt_write", rd_v, il_v);
    step(op_csr(CSR_MCYCLE, 3'b010, 1, 0, 0), "cnt_lo", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_written got %h exp ffffffff", rd_v); end
    step(op_csr(CSR_MCYCLEH, 3'b010, 1, 0, 0), "cnt_hi1", rd_v, il_v);
    n_tests++;
    if (rd_v !== hi0 + 32'd1) begin n_fail++; $display("FAIL cnt_carry got %h exp %h", rd_v, hi0 + 32'd1); end
    step(op_csr(CSR_MCYCLE, 3'b010, 1, 0, 0), "cnt_wrap", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'd1) begin n_fail++; $display("FAIL cnt_wrap got %h exp 00000001", rd_v); end
    for (int i = 0; i < 6; i++) begin
      op_t o = op_csr(CSR_MINSTRET, 3'b010, 1, 0, 0);
      o.ret = i[0];
      step(o, "instret", rd_v, il_v);
    end
  endtask

  task automatic test_illegal();
    op_t o;
    step(op_csr(CSR_MCAUSE, 3'b001, 0, 1, 32'h7), "ill_mcause_set", rd_v, il_v);
    step(op_csr(12'h7C0, 3'b010, 1, 0, 0), "ill_read", rd_v, il_v);
    n_tests++;
    if (il_v !== 1'b1 || rd_v !== 32'h0) begin
      n_fail++; $display("FAIL ill_read got %b/%h exp 1/00000000", il_v, rd_v);
    end
    step(op_csr(CSR_MCAUSE, 3'b010, 1, 0, 0), "ill_mcause", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'd2) begin n_fail++; $display("FAIL ill_mcause got %h exp 00000002", rd_v); end
    o = op_csr(CSR_MHARTID, 3'b001, 1, 1, 32'h1234); o.pc = 32'h80;
    step(o, "ill_hartid_wr", rd_v, il_v);
    n_tests++;
    if (il_v !== 1'b1) begin n_fail++; $display("FAIL ill_hartid_wr got %b exp 1", il_v); end
    step(op_csr(CSR_MHARTID, 3'b010, 1, 0, 0), "ill_hartid_rd", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'(TB_HART) || il_v !== 1'b0) begin
      n_fail++; $display("FAIL ill_hartid_rd got %h/%b exp %h/0", rd_v, il_v, 32'(TB_HART));
    end
    o = op_trap(32'h90, 32'h0); o.mret = 1;
    step(o, "ill_mret_both", rd_v, il_v);
    n_tests++;
    if (redirect_pc !== 32'h100) begin
      n_fail++; $display("FAIL ill_mret_both redirect_pc got %h exp 00000100", redirect_pc);
    end
  endtask

  task automatic test_back_to_back();
    op_t o = op_trap(32'h47, 32'hA5A5_0001);
    o.addr = CSR_MSCRATCH; o.sel = 3'b001; o.wr = 1; o.rs1 = 32'h5555;
    step(o, "b2b_first", rd_v, il_v);
    step(op_trap(32'h63, 32'h1), "b2b_second", rd_v, il_v);
    step(op_csr(CSR_MEPC, 3'b010, 1, 0, 0), "b2b_mepc", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'h60) begin n_fail++; $display("FAIL b2b_mepc got %h exp 00000060", rd_v); end
    step(op_csr(CSR_MSCRATCH, 3'b010, 1, 0, 0), "b2b_scratch", rd_v, il_v);
    n_tests++;
    if (rd_v !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_scratch got %h exp deadbeef", rd_v); end
  endtask

  task automatic test_async_reset();
    step(op_trap(32'h10, 32'h0), "arst_trap", rd_v, il_v);
    n_tests++;
    if (redirect !== 1'b1) begin n_fail++; $display("FAIL arst_pending got %b exp 1", redirect); end
    rst_n = 1'b0;
    csrread = 0; csrwrite = 0; illegal_ins = 0; is_mret = 0; retire = 0;
    #1;
    n_tests++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0 || mie_out !== 1'b0) begin
      n_fail++; $display("FAIL arst_drop got %b/%h/%b exp 0/00000000/0", redirect, redirect_pc, mie_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(op_csr(CSR_MTVEC, 3'b010, 1, 0, 0), "arst_mtvec", rd_v, il_v);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      op_t o = op_idle();
      int k = int'($urandom_range(0, 9));
      if (k < 6) begin
        o = op_csr(addr_list[$urandom_range(0, 12)], sel_list[$urandom_range(0, 5)],
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        if (k == 0) o.ill = 1;
      end else if (k < 8) begin
        o.ill = 1;
      end else if (k == 8) begin
        o.mret = 1; o.rd = 1'($urandom_range(0, 1)); o.addr = addr_list[$urandom_range(0, 12)];
        o.sel = 3'b010;
      end
      o.pc = $urandom; o.word = $urandom; o.ret = 1'($urandom_range(0, 1));
      step(o, "random", rd_v, il_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    csr_addr = '0; csrsel = '0; csrread = 0; csrwrite = 0; rs1_data = '0; uimm = '0;
    illegal_ins = 0; is_mret = 0; ins_pc = '0; ins_word = '0; retire = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    test_reset();
    test_scratch();
    test_mstatus();
    test_trap();
    test_mret();
    test_counter();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
